// File: rtl/pulse_divider_bank.sv
// Multi-channel programmable divider: arbitrary period, programmable high time, per-channel enable.
// Outputs are registered; a channel starts at phase 0 the cycle after en is first sampled high.
// No backpressure: new configuration is shadowed and applied only at a period boundary or while idle.
module pulse_divider_bank #(
  parameter int N        = 32,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   en,
  input  logic [CHANNELS*N-1:0] ticks,
  input  logic [CHANNELS*N-1:0] high,
  input  logic [CHANNELS-1:0]   load,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   tick
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] per_q, per_d;
    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] sh_per_q, sh_hi_q;
    logic         run_q, run_d;
    logic         pend_q, pend_d;
    logic         out_q, tick_q;
    logic         at_end, apply;

    // Next-state: apply shadow/port config at the period boundary or while idle, then advance phase
    always_comb begin
      per_d  = per_q;
      hi_d   = hi_q;
      pend_d = pend_q;
      // Boundary test is done at full N bits so P = 2^N-1 is usable
      at_end = run_q && (cnt_q == (per_q - ONE));
      apply  = at_end || !run_q;
      if (apply) begin
        pend_d = 1'b0;
        if (load[i]) begin
          // Config arriving exactly at an apply point bypasses the shadow
          per_d = ticks[i*N +: N];
          hi_d  = high[i*N +: N];
        end else if (pend_q) begin
          per_d = sh_per_q;
          hi_d  = sh_hi_q;
        end
      end else if (load[i]) begin
        pend_d = 1'b1;
      end
      run_d = en[i] && (per_d != '0);
      if (!run_d || apply) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    // State and registered outputs; reset aborts any period in flight and drops pending config
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        per_q    <= '0;
        hi_q     <= '0;
        sh_per_q <= '0;
        sh_hi_q  <= '0;
        run_q    <= 1'b0;
        pend_q   <= 1'b0;
        out_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        hi_q   <= hi_d;
        run_q  <= run_d;
        pend_q <= pend_d;
        if (load[i]) begin
          sh_per_q <= ticks[i*N +: N];
          sh_hi_q  <= high[i*N +: N];
        end
        out_q  <= run_d && (cnt_d < hi_d);
        tick_q <= run_d && (cnt_d == '0);
      end
    end

    assign pending[i] = pend_q;
    assign out[i]     = out_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_pulse_divider_bank.sv
// Scoreboard bench for pulse_divider_bank: directed stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares out/tick/pending for all channels every cycle.
// Expected waveforms come from hand-chosen periods/phases tracked as simple modular phase counts.
module tb_pulse_divider_bank;
  localparam int N = 32;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [C-1:0]   en;
  logic [C*N-1:0] ticks;
  logic [C*N-1:0] high;
  logic [C-1:0]   load;
  logic [C-1:0]   pending;
  logic [C-1:0]   out;
  logic [C-1:0]   tick;

  pulse_divider_bank #(.N(N), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .en(en), .ticks(ticks), .high(high),
    .load(load), .pending(pending), .out(out), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] o;
    logic [C-1:0] t;
    logic [C-1:0] p;
    string        nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // expected-behaviour state per channel: period, high time, phase of the next cycle, running, pending
  int m_p[C];
  int m_h[C];
  int m_ph[C];
  bit m_on[C];
  bit m_pend[C];

  // monitor: one expectation per cycle, compared away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++;
      if (out !== mon_e.o) begin
        bad++;
        $display("FAIL %s out got=%b want=%b t=%0t", mon_e.nm, out, mon_e.o, $time);
      end
      total++;
      if (tick !== mon_e.t) begin
        bad++;
        $display("FAIL %s tick got=%b want=%b t=%0t", mon_e.nm, tick, mon_e.t, $time);
      end
      total++;
      if (pending !== mon_e.p) begin
        bad++;
        $display("FAIL %s pending got=%b want=%b t=%0t", mon_e.nm, pending, mon_e.p, $time);
      end
    end
  end

  // one clock: expectation describes the cycle produced by the coming edge
  task automatic step(input string nm);
    exp_t e;
    e.o = '0;
    e.t = '0;
    e.p = '0;
    e.nm = nm;
    for (int i = 0; i < C; i++) begin
      e.o[i] = m_on[i] && (m_ph[i] < m_h[i]);
      e.t[i] = m_on[i] && (m_ph[i] == 0);
      e.p[i] = m_pend[i];
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    for (int i = 0; i < C; i++) begin
      if (m_on[i]) begin
        m_ph[i] = m_ph[i] + 1;
        if (m_ph[i] >= m_p[i]) m_ph[i] = 0;
      end
    end
  endtask

  task automatic steps(input int n, input string nm);
    for (int k = 0; k < n; k++) step(nm);
  endtask

  task automatic cfg(input int ch, input int p, input int h);
    ticks[ch*N +: N] = p;
    high[ch*N +: N]  = h;
    load[ch]         = 1'b1;
  endtask

  task automatic mset(input int ch, input int p, input int h, input bit on);
    m_p[ch]  = p;
    m_h[ch]  = h;
    m_on[ch] = on;
    m_ph[ch] = 0;
  endtask

  initial begin
    rst   = 1'b1;
    en    = '0;
    ticks = '0;
    high  = '0;
    load  = '0;
    for (int i = 0; i < C; i++) begin
      mset(i, 0, 0, 1'b0);
      m_pend[i] = 1'b0;
    end
    steps(2, "reset");
    rst = 1'b0;
    steps(2, "idle");

    // ch0: P=4 H=2 loaded and enabled together from idle -> 1,1,0,0
    cfg(0, 4, 2);
    en[0] = 1'b1;
    mset(0, 4, 2, 1'b1);
    step("p4_start");
    load = '0;
    steps(11, "p4_run");

    // reload mid-period; second load overwrites the first; switch at boundary to 1,1,1,0,0,0
    steps(2, "p4_pre");           // phases 0,1
    cfg(0, 9, 9);
    m_pend[0] = 1'b1;
    step("reload_ph2");           // load sampled ending phase 1
    cfg(0, 6, 3);
    step("reload_ph3");
    load = '0;
    m_p[0] = 6;
    m_h[0] = 3;
    m_pend[0] = 1'b0;
    steps(12, "p6_run");

    // disable mid-period with a load: goes idle at once, pending applied on the idle edge
    steps(2, "p6_pre");
    en[0] = 1'b0;
    cfg(0, 3, 1);
    m_on[0] = 1'b0;
    m_pend[0] = 1'b1;
    step("dis_load");
    load = '0;
    m_pend[0] = 1'b0;
    steps(2, "dis_idle");
    en[0] = 1'b1;
    mset(0, 3, 1, 1'b1);
    step("reen_first");
    steps(8, "reen_p3h1");
    en[0] = 1'b0;
    m_on[0] = 1'b0;
    step("ch0_off");

    // ch1: reset at phase 2 of P=8 with a pending load; also load/en on ch3 during reset
    cfg(1, 8, 3);
    en[1] = 1'b1;
    mset(1, 8, 3, 1'b1);
    step("p8_ph0");
    load = '0;
    step("p8_ph1");
    cfg(1, 5, 1);
    m_pend[1] = 1'b1;
    step("p8_ph2_pend");
    load = '0;
    rst = 1'b1;
    cfg(3, 3, 1);
    en[3] = 1'b1;
    for (int i = 0; i < C; i++) begin
      mset(i, 0, 0, 1'b0);
      m_pend[i] = 1'b0;
    end
    step("rst_mid");
    rst = 1'b0;
    load = '0;
    steps(4, "p0_en_idle");
    en = '0;
    step("all_off");

    // ch1: P=5 H=2 for 1000 periods, checked every cycle
    cfg(1, 5, 2);
    en[1] = 1'b1;
    mset(1, 5, 2, 1'b1);
    step("p5_start");
    load = '0;
    steps(4999, "p5_long");
    en[1] = 1'b0;
    m_on[1] = 1'b0;
    step("ch1_off");

    // ch2 edge configs: P=1 H=1, then P=3 H=0 at boundary, then P=3 H=7
    cfg(2, 1, 1);
    en[2] = 1'b1;
    mset(2, 1, 1, 1'b1);
    step("p1_start");
    load = '0;
    steps(4, "p1h1");
    cfg(2, 3, 0);
    mset(2, 3, 0, 1'b1);
    step("p3h0_first");
    load = '0;
    steps(8, "p3h0");
    en[2] = 1'b0;
    m_on[2] = 1'b0;
    step("ch2_off");
    cfg(2, 3, 7);
    en[2] = 1'b1;
    mset(2, 3, 7, 1'b1);
    step("p3h7_first");
    load = '0;
    steps(8, "p3h7");
    en[2] = 1'b0;
    m_on[2] = 1'b0;
    step("ch2_off2");

    // four channels together, then a load on ch2 landing exactly on its boundary
    cfg(0, 2, 1);
    cfg(1, 3, 2);
    cfg(2, 7, 3);
    cfg(3, 16, 5);
    en = '1;
    mset(0, 2, 1, 1'b1);
    mset(1, 3, 2, 1'b1);
    mset(2, 7, 3, 1'b1);
    mset(3, 16, 5, 1'b1);
    step("multi_start");
    load = '0;
    steps(40, "multi_run");
    for (int k = 0; k < 7 && m_ph[2] != 0; k++) step("multi_align");
    cfg(2, 4, 3);
    m_p[2] = 4;
    m_h[2] = 3;
    step("multi_bnd_load");
    load = '0;
    steps(32, "multi_after");
    en = '0;
    for (int i = 0; i < C; i++) m_on[i] = 1'b0;
    steps(2, "multi_off");

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
